fsm_step_sequencer: RTL
=======================

// Module: fsm_step_sequencer
// PURPOSE
//  Parametrised multi-state step sequencer with a clean, fully-specified next-state case.
//  Walks indices 0..NUM_STATES-1 and holds each for a programmable dwell.
//  Has a start/done handshake, abort, and recovery from illegal encodings.
//  Sits between a control master and downstream per-phase enables.
// PARAMETERS
//  NUM_STATES  4  number of sequence steps, >=2; need not be a power of two
//  CNT_W       8  width of dwell counter and dwell_i
//  IDX_W       derived localparam = $clog2(NUM_STATES); not overridable
// PORTS
//  clk             input   1           single clock, all logic on posedge
//  rst             input   1           synchronous reset, active-high
//  start_i         input   1           request a sequence run; sampled only in IDLE
//  abort_i         input   1           terminate run; return to IDLE
//  dwell_i         input   CNT_W       cycles per step, latched on accepted start
//  busy_o          output  1           high while in RUN
//  state_o         output  IDX_W       current step index
//  state_onehot_o  output  NUM_STATES  one-hot of state_o in RUN; all-zero otherwise
//  step_o          output  1           1-cycle pulse in the first cycle of steps 1..N-1
//  done_o          output  1           1-cycle pulse when the final step completes
//  err_o           output  1           1-cycle pulse when an illegal index is recovered
// BEHAVIOUR
//  Top FSM: IDLE -> RUN -> DONE -> IDLE. All outputs are registered.
//  Reset (rst=1 at posedge): FSM=IDLE, index=0, counter=0, all outputs 0.
//  IDLE:
//    - start_i=1 and abort_i=0 -> RUN.
//    - index=0, counter=0, dwell latched.
//    - busy_o=1 from the next cycle (1-cycle latency).
//  Effective dwell:
//    - max(dwell_i,1); dwell_i=0 is treated as 1.
//    - dwell_i changes during RUN are ignored.
//  RUN, counter == effective dwell-1:
//    - If index < NUM_STATES-1: index+1, counter=0, step_o=1 next cycle.
//    - If index == NUM_STATES-1: go to DONE.
//  DONE: lasts 1 cycle; done_o=1, busy_o=0, state_onehot_o=0; then IDLE.
//  abort_i=1 in RUN or DONE:
//    - IDLE next cycle, index=0, no done_o.
//    - abort_i wins over start_i and over a simultaneous step expiry.
//  start_i while busy or in DONE: ignored, not queued.
//  Illegal index (>= NUM_STATES, reachable only if NUM_STATES is not 2^k):
//    - Case default forces index=0 and counter=0, pulses err_o; FSM stays RUN.
//  Illegal top-FSM encoding: default -> IDLE, err_o pulse.
//  Every case has a default; every comb output has a default assignment (no latches).
//  Each signal has exactly one driver.
//  Counter arithmetic is CNT_W-bit unsigned; it never wraps because its bound is dwell-1.
// CONFIGURATION
//  Macro SEQ_LOOP_EN adds input port loop_i (1 bit).
//  Defined, with loop_i=1 at final-step expiry:
//    - index wraps to 0, step_o=1, done_o=1 (per-pass pulse), busy_o stays 1.
//    - DONE is skipped; run continues until abort_i or final expiry with loop_i=0.
//  Undefined: no loop_i port; single pass only, behaviour exactly as above.
// STRUCTURE
//  Package fsm_seq_pkg: top-state localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
//    2'd3 is illegal and recovered.
//  Sub-module seq_dwell_counter (CNT_W):
//    - Ports: clr, load(dwell), en; output expire.
//    - Instantiated once.
//  Top holds FSM, index register, one-hot decode and output registers.
// TESTING
//  1. rst=1 2 cycles -> all outputs 0, state_onehot_o=4'b0000.
//  2. N=4, dwell=3, start at cyc 0 -> busy cyc 1-12.
//     state_o 0,1,2,3 at cyc 1,4,7,10; step_o at 4,7,10; done_o at cyc 13 only.
//  3. dwell_i=0, start -> each step held 1 cycle; done_o 5 cycles after start.
//  4. abort_i at cyc 5 of scenario 2 -> IDLE at cyc 6, done_o never asserted.
//     abort_i+start_i together in IDLE -> stays IDLE.
//  5. start_i pulsed at cyc 3 while busy -> ignored; timing identical to scenario 2.
//  6. NUM_STATES=3: force index=2'd3 -> err_o one pulse, state_o=0 next cycle.
//     SEQ_LOOP_EN with loop_i=1 -> state_o 3->0, done_o pulse, busy_o stays 1.

Source files
------------

// File: rtl/fsm_seq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : fsm_seq_pkg                                           |
// | Brief    : Shared top-state encodings for the step sequencer.    |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package fsm_seq_pkg;

  localparam int TOP_W = 2;

  // Top-level FSM encodings; 2'd3 is unused and recovered to IDLE.
  localparam logic [TOP_W-1:0] ST_IDLE = 2'd0;
  localparam logic [TOP_W-1:0] ST_RUN  = 2'd1;
  localparam logic [TOP_W-1:0] ST_DONE = 2'd2;

endpackage : fsm_seq_pkg
`default_nettype wire

// File: rtl/seq_dwell_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : seq_dwell_counter                                     |
// | Brief    : Per-step dwell counter. 'load' latches the dwell      |
// |            (0 treated as 1) and zeroes the count, 'clr' zeroes   |
// |            the count, 'en' advances it. 'expire' flags the last  |
// |            cycle of a step; the count then restarts at 0.        |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module seq_dwell_counter
  import fsm_seq_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] dwell,
  input  logic             en,
  output logic             expire
);

  // lim holds effective dwell minus one, so the count never wraps.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lim_q, lim_d;

  assign expire = en && (cnt_q == lim_q);

  // Next count/limit: load beats clear, clear beats counting.
  always_comb begin
    cnt_d = cnt_q;
    lim_d = lim_q;
    if (load) begin
      lim_d = (dwell == '0) ? '0 : dwell - 1'b1;
      cnt_d = '0;
    end else if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = expire ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      lim_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      lim_q <= lim_d;
    end
  end

endmodule : seq_dwell_counter
`default_nettype wire

// File: rtl/fsm_step_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : fsm_step_sequencer                                    |
// | Brief    : Walks step indices 0..NUM_STATES-1, holding each for  |
// |            a latched dwell. Start/done handshake, abort, and     |
// |            recovery of illegal index/state encodings.            |
// |            Optional macro SEQ_LOOP_EN adds loop_i: a final-step  |
// |            expiry with loop_i=1 wraps to step 0 instead of DONE. |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module fsm_step_sequencer
  import fsm_seq_pkg::*;
#(
  parameter  int NUM_STATES = 4,
  parameter  int CNT_W      = 8,
  localparam int IDX_W      = $clog2(NUM_STATES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  abort_i,
`ifdef SEQ_LOOP_EN
  input  logic                  loop_i,
`endif
  input  logic [CNT_W-1:0]      dwell_i,
  output logic                  busy_o,
  output logic [IDX_W-1:0]      state_o,
  output logic [NUM_STATES-1:0] state_onehot_o,
  output logic                  step_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NUM_STATES - 1);

  logic [TOP_W-1:0]      state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  busy_q, busy_d;
  logic [NUM_STATES-1:0] onehot_q, onehot_d;
  logic                  step_q, step_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [NUM_STATES-1:0] idx_dec;
  logic                  idx_legal;
  logic                  loop_en;
  logic                  cnt_clr, cnt_load, cnt_en, cnt_expire;

  // An index is legal only if it decodes to one of the real steps.
  for (genvar i = 0; i < NUM_STATES; i++) begin : g_idx_dec
    assign idx_dec[i] = (idx_q == IDX_W'(i));
  end
  assign idx_legal = |idx_dec;

`ifdef SEQ_LOOP_EN
  assign loop_en = loop_i;
`else
  assign loop_en = 1'b0;
`endif

  assign cnt_en = (state_q == ST_RUN);

  seq_dwell_counter #(
    .CNT_W (CNT_W)
  ) u_dwell_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .load   (cnt_load),
    .dwell  (dwell_i),
    .en     (cnt_en),
    .expire (cnt_expire)
  );

  // Next FSM state, step index, counter control and pulse outputs.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    step_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idx_d   = '0;
        cnt_clr = 1'b1;
        if (start_i && !abort_i) begin
          state_d  = ST_RUN;
          cnt_load = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_clr = 1'b1;
        end else if (!idx_legal) begin
          idx_d   = '0;
          cnt_clr = 1'b1;
          err_d   = 1'b1;
        end else if (cnt_expire) begin
          if (idx_q != C_IDX_LAST) begin
            idx_d  = idx_q + IDX_W'(1);
            step_d = 1'b1;
          end else if (loop_en) begin
            idx_d  = '0;
            step_d = 1'b1;
            done_d = 1'b1;
          end else begin
            state_d = ST_DONE;
            idx_d   = '0;
            done_d  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        cnt_clr = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        cnt_clr = 1'b1;
        err_d   = 1'b1;
      end
    endcase
  end

  // Busy and one-hot outputs follow the next state so they register cleanly.
  always_comb begin
    busy_d   = (state_d == ST_RUN);
    onehot_d = '0;
    for (int i = 0; i < NUM_STATES; i++) begin
      if (busy_d && (idx_d == IDX_W'(i))) begin
        onehot_d[i] = 1'b1;
      end
    end
  end

  // State, index and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      onehot_q <= '0;
      step_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      onehot_q <= onehot_d;
      step_q   <= step_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign busy_o         = busy_q;
  assign state_o        = idx_q;
  assign state_onehot_o = onehot_q;
  assign step_o         = step_q;
  assign done_o         = done_q;
  assign err_o          = err_q;

endmodule : fsm_step_sequencer
`default_nettype wire
